mem_arbiter: RTL and testbench

- Two-requester arbiter for the single 256-bit off-chip data memory port.
- Port 0 is the instruction-cache refill path; port 1 is dcache_top's memory side.
- Grants one requester at a time with round-robin priority and latches its request for the whole transaction.
- Sits between the CPU top-level memory pins and both caches, and holds the grant until the memory acknowledges.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter for the 256-bit memory port (optional watchdog: MEM_ARB_TIMEOUT_EN)
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t state;
  // 0 = port 0 served last, 1 = port 1 served last; a tie goes to the other one
  logic   last_served;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] busy_cnt;
  logic             err_q;
  assign err_o = err_q;
`else
  // No watchdog: the flag is constant, the parameter stays referenced so both builds share one interface
  assign err_o = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Acks and read data are combinational so the owner sees completion in the memory ack cycle
  assign p0_ack_o  = (state == BUSY0) && mem_ack_i;
  assign p1_ack_o  = (state == BUSY1) && mem_ack_i;
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

  // Arbitration FSM; memory-side outputs are registers loaded only on the grant edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last_served  <= 1'b1;
      grant_o      <= 2'b00;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      busy_cnt     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (p0_enable_i && (!p1_enable_i || last_served)) begin
            state        <= BUSY0;
            grant_o      <= 2'b01;
            mem_enable_o <= 1'b1;
            mem_write_o  <= p0_write_i;
            mem_addr_o   <= p0_addr_i;
            mem_data_o   <= p0_data_i;
          end else if (p1_enable_i) begin
            state        <= BUSY1;
            grant_o      <= 2'b10;
            mem_enable_o <= 1'b1;
            mem_write_o  <= p1_write_i;
            mem_addr_o   <= p1_addr_i;
            mem_data_o   <= p1_data_i;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          busy_cnt <= '0;
`endif
        end
        BUSY0, BUSY1: begin
          if (mem_ack_i) begin
            state        <= IDLE;
            grant_o      <= 2'b00;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            last_served  <= (state == BUSY1);
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the transaction without an ack; the owner stays stalled
            state        <= IDLE;
            grant_o      <= 2'b00;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            err_q        <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state        <= IDLE;
          grant_o      <= 2'b00;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (timeout checks under MEM_ARB_TIMEOUT_EN)
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          p0_enable_i = 1'b0, p0_write_i = 1'b0;
  logic [AW-1:0] p0_addr_i = '0;
  logic [DW-1:0] p0_data_i = '0;
  logic [DW-1:0] p0_data_o;
  logic          p0_ack_o;
  logic          p1_enable_i = 1'b0, p1_write_i = 1'b0;
  logic [AW-1:0] p1_addr_i = '0;
  logic [DW-1:0] p1_data_i = '0;
  logic [DW-1:0] p1_data_o;
  logic          p1_ack_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_data_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_enable_o, mem_write_o, err_o;
  logic [1:0]    grant_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
    .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .grant_o(grant_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: who owns the port, what was captured, who was served last
  int            m_owner = 0;        // 0 none, 1 port 0, 2 port 1
  bit            m_last = 1'b1;      // last served port number
  bit            m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_busy = 0;
  bit            m_err = 1'b0;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_owner = 0; m_last = 1'b1; m_busy = 0; m_err = 1'b0;
    end else if (m_owner == 0) begin
      int win;
      win = -1;
      if (p0_enable_i && p1_enable_i) win = m_last ? 0 : 1;
      else if (p0_enable_i)           win = 0;
      else if (p1_enable_i)           win = 1;
      if (win >= 0) begin
        m_owner = win + 1;
        m_busy  = 0;
        m_write = (win == 0) ? p0_write_i : p1_write_i;
        m_addr  = (win == 0) ? p0_addr_i  : p1_addr_i;
        m_data  = (win == 0) ? p0_data_i  : p1_data_i;
      end
    end else if (mem_ack_i) begin
      m_last  = (m_owner == 2);
      m_owner = 0;
    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
      m_busy++;
      if (m_busy == TO) begin
        m_owner = 0;
        m_err   = 1'b1;
      end
`endif
    end
  end

  bit         cmp_on = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] order[$];

  // Every-cycle comparison of the DUT against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      logic [1:0] eg;
      eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      chk("grant", grant_o, eg);
      chk("mem_enable", mem_enable_o, m_owner != 0);
      chk("mem_write", mem_write_o, (m_owner != 0) && m_write);
      if (m_owner != 0) begin
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_data", mem_data_o, m_data);
      end
      chk("p0_ack", p0_ack_o, (m_owner == 1) && mem_ack_i);
      chk("p1_ack", p1_ack_o, (m_owner == 2) && mem_ack_i);
      if (p0_ack_o) chk("p0_data", p0_data_o, mem_data_i);
      if (p1_ack_o) chk("p1_data", p1_data_o, mem_data_i);
      chk("err", err_o, m_err);
      if (grant_o != 2'b00 && prev_grant == 2'b00) order.push_back(grant_o);
      prev_grant = grant_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    int n;
    n = 0;
    while (grant_o !== g && n < 20) begin
      tick(1);
      n++;
    end
    chk({name, "_grant_wait"}, grant_o, g);
  endtask

  task automatic do_ack(input logic [DW-1:0] d);
    mem_data_i = d;
    mem_ack_i  = 1'b1;
    tick(1);
    mem_ack_i  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] a5;
    a5 = {8{32'hA5A5A5A5}};

    // Reset state
    tick(2);
    chk("rst_mem_enable", mem_enable_o, 1'b0);
    chk("rst_mem_write", mem_write_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_err", err_o, 1'b0);
    chk("rst_acks", {p0_ack_o, p1_ack_o}, 2'b00);
    rst_i = 1'b1;
    cmp_on = 1'b1;
    tick(1);

    // Port 1 read alone, ack after 10 cycles
    p1_addr_i = 32'h0000_0400; p1_write_i = 1'b0; p1_enable_i = 1'b1;
    #1 chk("t1_no_enable_yet", mem_enable_o, 1'b0);
    tick(1);
    chk("t1_enable", mem_enable_o, 1'b1);
    chk("t1_grant", grant_o, 2'b10);
    chk("t1_addr", mem_addr_o, 32'h0000_0400);
    tick(9);
    mem_data_i = {8{32'h1234_5678}};
    mem_ack_i  = 1'b1;
    #1;
    chk("t1_p1_ack", p1_ack_o, 1'b1);
    chk("t1_p0_ack", p0_ack_o, 1'b0);
    chk("t1_p1_data", p1_data_o, {8{32'h1234_5678}});
    tick(1);
    mem_ack_i = 1'b0; p1_enable_i = 1'b0;
    chk("t1_grant_idle", grant_o, 2'b00);
    chk("t1_enable_low", mem_enable_o, 1'b0);
    tick(1);

    // Simultaneous requests straight after reset: port 0 first
    rst_i = 1'b0; tick(1); rst_i = 1'b1;
    p0_addr_i = 32'h10; p1_addr_i = 32'h20;
    p0_enable_i = 1'b1; p1_enable_i = 1'b1;
    tick(1);
    chk("t2_first_grant", grant_o, 2'b01);
    tick(2);
    do_ack({8{32'h0BAD_F00D}});
    p0_enable_i = 1'b0;
    chk("t2_gap_grant", grant_o, 2'b00);
    tick(1);
    chk("t2_second_grant", grant_o, 2'b10);
    chk("t2_second_addr", mem_addr_o, 32'h20);
    do_ack({8{32'hCAFE_0001}});
    p1_enable_i = 1'b0;
    tick(2);

    // Both held through four transactions; port 0 writes
    order.delete();
    p0_write_i = 1'b1; p0_addr_i = 32'h40; p0_data_i = a5;
    p1_write_i = 1'b0; p1_addr_i = 32'h80;
    p0_enable_i = 1'b1; p1_enable_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant((i % 2 == 0) ? 2'b01 : 2'b10, "t3");
      if (i % 2 == 0) begin
        chk("t3_write", mem_write_o, 1'b1);
        chk("t3_wdata", mem_data_o, a5);
      end
      tick(3);
      do_ack({8{$urandom}});
    end
    p0_enable_i = 1'b0; p1_enable_i = 1'b0;
    tick(2);
    chk("t3_order_len", order.size(), 4);
    if (order.size() == 4) begin
      chk("t3_order0", order[0], 2'b01);
      chk("t3_order1", order[1], 2'b10);
      chk("t3_order2", order[2], 2'b01);
      chk("t3_order3", order[3], 2'b10);
    end

    // Memory ack while idle, then a mid-transaction address change
    p0_write_i = 1'b0;
    mem_ack_i = 1'b1;
    #1 chk("t4_idle_acks", {p0_ack_o, p1_ack_o}, 2'b00);
    tick(1);
    mem_ack_i = 1'b0;
    chk("t4_idle_grant", grant_o, 2'b00);
    p0_addr_i = 32'h100; p0_enable_i = 1'b1;
    wait_grant(2'b01, "t4");
    p0_addr_i = 32'h200;
    tick(2);
    chk("t4_addr_held", mem_addr_o, 32'h100);
    do_ack({8{32'h5555_AAAA}});
    p0_enable_i = 1'b0;
    tick(1);

    // Reset three cycles into BUSY1, late ack ignored
    p1_addr_i = 32'h300; p1_enable_i = 1'b1;
    wait_grant(2'b10, "t5");
    tick(3);
    rst_i = 1'b0;
    #1;
    chk("t5_rst_enable", mem_enable_o, 1'b0);
    chk("t5_rst_grant", grant_o, 2'b00);
    p1_enable_i = 1'b0;
    tick(1);
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    #1 chk("t5_late_ack", p1_ack_o, 1'b0);
    tick(1);
    mem_ack_i = 1'b0;
    tick(1);

    // Watchdog behaviour
    p0_addr_i = 32'h500; p0_enable_i = 1'b1;
    wait_grant(2'b01, "t6");
    p0_enable_i = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tick(TO + 2);
    chk("t6_err_set", err_o, 1'b1);
    chk("t6_idle", grant_o, 2'b00);
    tick(3);
    chk("t6_err_sticky", err_o, 1'b1);
`else
    tick(80);
    chk("t6_err_zero", err_o, 1'b0);
    chk("t6_still_busy", grant_o, 2'b01);
    do_ack({8{32'h7777_0000}});
`endif
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
